// File: rtl/approx_add_err_stats.sv
// Error-statistics collector for 16-bit approximate adders: recomputes the exact sum and accumulates ED stats.
// Optional macro APPROX_ERR_SSE_EN builds the squared-error datapath and the sse accumulator.
module approx_add_err_stats #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic [ACC_W-1:0] sse,
    output logic             sat
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             flush_cnt;
    logic             accept;
    logic             run_start;
    logic [WIDTH:0]   exact_c;
    logic             vld_p1;
    logic [WIDTH:0]   ed_p1;
    logic [ACC_W:0]   sum_nxt;
    logic [CNT_W:0]   cnt_nxt;
    logic             sse_ovf;

    function automatic logic [WIDTH:0] abs_ed(input logic [WIDTH:0] approx, input logic [WIDTH:0] exact);
        if (approx >= exact) return approx - exact;
        else return exact - approx;
    endfunction

    // Returns {overflow, value}; value clamps at all-ones on overflow.
    function automatic logic [ACC_W:0] acc_add_sat(input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
    endfunction

    function automatic logic [CNT_W:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (&c) ? {1'b1, c} : {1'b0, c + CNT_W'(1)};
    endfunction

    assign in_ready  = (state == RUN) && (remaining != '0);
    assign accept    = in_valid & in_ready;
    assign run_start = (state == IDLE) && start;
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
            RUN:     if (accept && remaining == CNT_W'(1)) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (run_start) remaining <= num_samples;
            else if (accept) remaining <= remaining - CNT_W'(1);
        end
    end

    // Stage 1: the reference sum is taken at operand width, carry dropped, then zero-extended.
    assign exact_c = {1'b0, in_a + in_b};

    always_ff @(posedge clk) begin
        if (accept) ed_p1 <= abs_ed(in_approx, exact_c);
    end

    // Stage 2: saturating accumulation of the run statistics.
    assign sum_nxt = acc_add_sat(sum_ed, ACC_W'(ed_p1));
    assign cnt_nxt = cnt_inc_sat(err_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
            sat       <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (run_start) begin
                err_count <= '0;
                max_ed    <= '0;
                sum_ed    <= '0;
                sat       <= 1'b0;
            end else if (vld_p1) begin
                if (ed_p1 != '0) err_count <= cnt_nxt[CNT_W-1:0];
                if (ed_p1 > max_ed) max_ed <= ed_p1;
                sum_ed <= sum_nxt[ACC_W-1:0];
                sat    <= sat | sum_nxt[ACC_W] | sse_ovf | ((ed_p1 != '0) & cnt_nxt[CNT_W]);
            end
        end
    end

`ifdef APPROX_ERR_SSE_EN
    logic [2*WIDTH+1:0] ed_sq;
    logic [ACC_W:0]     sse_nxt;
    logic [ACC_W-1:0]   sse_r;

    assign ed_sq   = (2*WIDTH+2)'(ed_p1) * (2*WIDTH+2)'(ed_p1);
    assign sse_nxt = acc_add_sat(sse_r, ACC_W'(ed_sq));
    assign sse_ovf = sse_nxt[ACC_W];
    assign sse     = sse_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sse_r <= '0;
        else if (run_start) sse_r <= '0;
        else if (vld_p1) sse_r <= sse_nxt[ACC_W-1:0];
    end
`else
    assign sse_ovf = 1'b0;
    assign sse     = '0;
`endif

endmodule

// File: tb/tb_approx_add_err_stats.sv
// Bench for approx_add_err_stats: three parameterisations driven in lockstep, checked against a plain-arithmetic model.
module tb_approx_add_err_stats;

`ifdef APPROX_ERR_SSE_EN
    localparam bit SSE_ON = 1'b1;
`else
    localparam bit SSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid;
    logic [15:0] num_samples, in_a, in_b;
    logic [16:0] in_approx;

    logic        in_ready, busy, done, sat;
    logic [15:0] err_count;
    logic [16:0] max_ed;
    logic [47:0] sum_ed, sse;

    logic        t_rdy, t_busy, t_done, t_sat;
    logic [15:0] t_err;
    logic [16:0] t_max;
    logic [33:0] t_sum, t_sse;

    logic        s_rdy, s_busy, s_done, s_sat;
    logic [7:0]  s_err;
    logic [4:0]  s_max;
    logic [9:0]  s_sum, s_sse;

    approx_add_err_stats #(.WIDTH(16), .CNT_W(16), .ACC_W(48)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
        .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(busy), .done(done),
        .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed), .sse(sse), .sat(sat));

    approx_add_err_stats #(.WIDTH(16), .CNT_W(16), .ACC_W(34)) u_d34 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
        .in_ready(t_rdy), .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(t_busy), .done(t_done),
        .err_count(t_err), .max_ed(t_max), .sum_ed(t_sum), .sse(t_sse), .sat(t_sat));

    approx_add_err_stats #(.WIDTH(4), .CNT_W(8), .ACC_W(10)) u_small (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples[7:0]), .in_valid(in_valid),
        .in_ready(s_rdy), .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_approx(in_approx[4:0]), .busy(s_busy),
        .done(s_done), .err_count(s_err), .max_ed(s_max), .sum_ed(s_sum), .sse(s_sse), .sat(s_sat));

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt, last_acc, done_cyc, done_pulses;
    logic busy_at_done, rdy_after;

    logic [15:0] sa [64];
    logic [15:0] sb [64];
    logic [16:0] sx [64];

    typedef struct {
        logic [63:0] err, mx, sum, sse;
        logic        sat;
    } exp_t;

    // Reference: totals over the run with plain integers, clamped to the accumulator range at the end.
    function automatic exp_t model(input int n, input int w, input int accw);
        exp_t e;
        longint unsigned m, a, b, x, ex, ed, s1, s2, mx, top;
        int errs;
        m = (64'd1 << w) - 1;
        s1 = 0; s2 = 0; mx = 0; errs = 0;
        for (int i = 0; i < n; i++) begin
            a  = longint'(sa[i]) & m;
            b  = longint'(sb[i]) & m;
            x  = longint'(sx[i]) & ((m << 1) | 1);
            ex = (a + b) & m;
            ed = (x > ex) ? x - ex : ex - x;
            if (ed != 0) errs++;
            if (ed > mx) mx = ed;
            s1 += ed;
            s2 += ed * ed;
        end
        top   = (64'd1 << accw) - 1;
        e.err = 64'(errs);
        e.mx  = mx;
        e.sum = (s1 > top) ? top : s1;
        e.sse = SSE_ON ? ((s2 > top) ? top : s2) : 64'd0;
        e.sat = (s1 > top) || (SSE_ON && (s2 > top));
        return e;
    endfunction

    task automatic set_s(input int i, input logic [15:0] a, input logic [15:0] b, input logic [16:0] x);
        sa[i] = a; sb[i] = b; sx[i] = x;
    endtask

    // Pulses start in the current cycle (cycle 0) and feeds samples; cycles are counted from the start edge.
    task automatic do_run(input int n, input bit toggle, input int inj, input int hold);
        int cyc, idx;
        bit rq;
        acc_cnt = 0; last_acc = -10; done_cyc = -1; done_pulses = 0;
        busy_at_done = 1'bx; rdy_after = 1'bx; idx = 0; rq = 0; cyc = 0;
        start = 1'b1; num_samples = 16'(n); in_valid = 1'b0;
        while (cyc < 600) begin
            @(posedge clk);
            if (in_valid && rq) begin acc_cnt++; last_acc = cyc; idx++; end
            cyc++;
            #1;
            start = (cyc == inj);
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
            end
            if (cyc == last_acc + 1) rdy_after = in_ready;
            if (done_cyc >= 0 && cyc >= done_cyc + hold) break;
            rq = in_ready;
            in_valid = toggle ? cyc[0] : 1'b1;
            in_a = sa[idx % 64]; in_b = sb[idx % 64]; in_approx = sx[idx % 64];
        end
        start = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (done_cyc < 0) begin n_err++; $display("FAIL run_timeout: done not seen, required within 600 cycles"); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0; in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({busy, done, in_ready, sat} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, in_ready, sat}); end
        n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL reset_err_count: got %0h want 0", err_count); end
        n_vec++; if (max_ed !== '0) begin n_err++; $display("FAIL reset_max_ed: got %0h want 0", max_ed); end
        n_vec++; if (sum_ed !== '0 || sse !== '0) begin n_err++; $display("FAIL reset_acc: got %0h/%0h want 0/0", sum_ed, sse); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        set_s(0, 16'd1, 16'd1, 17'd3);
        do_run(1, 1'b0, -1, 1);
        n_vec++; if (done_cyc - last_acc != 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", done_cyc - last_acc); end
        n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL single_err_count: got %0h want 1", err_count); end
        n_vec++; if (max_ed !== 17'd1) begin n_err++; $display("FAIL single_max_ed: got %0h want 1", max_ed); end
        n_vec++; if (sum_ed !== 48'd1) begin n_err++; $display("FAIL single_sum_ed: got %0h want 1", sum_ed); end
        n_vec++; if (sse !== 48'(SSE_ON)) begin n_err++; $display("FAIL single_sse: got %0h want %0h", sse, SSE_ON); end
    endtask

    task automatic test_four();
        set_s(0, 16'h0000, 16'h0000, 17'h00000);
        set_s(1, 16'h0005, 16'h0003, 17'h00008);
        set_s(2, 16'hFFFF, 16'h0001, 17'h0FFFF);
        set_s(3, 16'h0002, 16'h0002, 17'h00007);
        do_run(4, 1'b0, -1, 1);
        n_vec++; if (err_count !== 16'd2) begin n_err++; $display("FAIL four_err_count: got %0h want 2", err_count); end
        n_vec++; if (max_ed !== 17'h0FFFF) begin n_err++; $display("FAIL four_max_ed: got %0h want ffff", max_ed); end
        n_vec++; if (sum_ed !== 48'h10002) begin n_err++; $display("FAIL four_sum_ed: got %0h want 10002", sum_ed); end
        n_vec++; if (sse !== (SSE_ON ? 48'hFFFE000A : 48'h0)) begin n_err++; $display("FAIL four_sse: got %0h want %0h", sse, SSE_ON ? 48'hFFFE000A : 48'h0); end
        n_vec++; if (sat !== 1'b0) begin n_err++; $display("FAIL four_sat: got %b want 0", sat); end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom);
            sx[i] = {1'b0, sa[i] + sb[i]} + 17'd1;
        end
        do_run(8, 1'b1, -1, 1);
        n_vec++; if (acc_cnt != 8) begin n_err++; $display("FAIL toggle_accepts: got %0d want 8", acc_cnt); end
        n_vec++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL toggle_ready_drop: got %b want 0", rdy_after); end
        n_vec++; if (sum_ed !== 48'd8) begin n_err++; $display("FAIL toggle_sum_ed: got %0h want 8", sum_ed); end
        n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL toggle_busy_at_done: got %b want 0", busy_at_done); end
        n_vec++; if (done_cyc - last_acc != 3) begin n_err++; $display("FAIL toggle_latency: got %0d want 3", done_cyc - last_acc); end
    endtask

    task automatic test_zero();
        do_run(0, 1'b0, -1, 1);
        n_vec++; if (acc_cnt != 0) begin n_err++; $display("FAIL zero_accepts: got %0d want 0", acc_cnt); end
        n_vec++; if (done_cyc != 1 || done_pulses != 1) begin n_err++; $display("FAIL zero_done: got cycle %0d pulses %0d want 1/1", done_cyc, done_pulses); end
        n_vec++; if ({err_count, max_ed, sum_ed, sse} !== '0) begin n_err++; $display("FAIL zero_stats: got %0h/%0h/%0h/%0h want 0", err_count, max_ed, sum_ed, sse); end
    endtask

    task automatic test_start_in_run();
        exp_t e;
        set_s(0, 16'd10, 16'd20, 17'd31);
        set_s(1, 16'd7, 16'd7, 17'd4);
        set_s(2, 16'd3, 16'd3, 17'd6);
        set_s(3, 16'd1, 16'd1, 17'd200);
        do_run(3, 1'b0, 2, 1);
        e = model(3, 16, 48);
        n_vec++; if (acc_cnt != 3) begin n_err++; $display("FAIL startrun_accepts: got %0d want 3", acc_cnt); end
        n_vec++; if (64'(err_count) !== e.err) begin n_err++; $display("FAIL startrun_err_count: got %0h want %0h", err_count, e.err); end
        n_vec++; if (64'(sum_ed) !== e.sum) begin n_err++; $display("FAIL startrun_sum_ed: got %0h want %0h", sum_ed, e.sum); end
    endtask

    task automatic test_back_to_back();
        set_s(0, 16'd1, 16'd1, 17'd3);
        set_s(1, 16'd2, 16'd2, 17'd9);
        do_run(1, 1'b0, 4, 8);
        n_vec++; if (acc_cnt != 1 || done_pulses != 1) begin n_err++; $display("FAIL b2b_start_in_done: got %0d accepts %0d dones want 1/1", acc_cnt, done_pulses); end
        do_run(1, 1'b0, 5, 8);
        n_vec++; if (acc_cnt != 2 || done_pulses != 2) begin n_err++; $display("FAIL b2b_first_idle_start: got %0d accepts %0d dones want 2/2", acc_cnt, done_pulses); end
        n_vec++; if (sum_ed !== 48'd5) begin n_err++; $display("FAIL b2b_sum_ed: got %0h want 5", sum_ed); end
    endtask

    task automatic test_midrun_reset();
        set_s(0, 16'd4, 16'd4, 17'd20);
        set_s(1, 16'd9, 16'd1, 17'd1);
        start = 1'b1; num_samples = 16'd4; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = sa[i]; in_b = sb[i]; in_approx = sx[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if ({busy, done, in_ready, sat} !== 4'b0) begin n_err++; $display("FAIL midrst_ctrl: got %b want 0000", {busy, done, in_ready, sat}); end
        n_vec++; if ({err_count, max_ed, sum_ed, sse} !== '0) begin n_err++; $display("FAIL midrst_stats: got %0h/%0h/%0h/%0h want 0", err_count, max_ed, sum_ed, sse); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({busy, in_ready, err_count, sum_ed} !== '0) begin n_err++; $display("FAIL midrst_idle: got busy %b ready %b err %0h sum %0h want 0", busy, in_ready, err_count, sum_ed); end
        set_s(0, 16'd1, 16'd1, 17'd3);
        do_run(1, 1'b0, -1, 1);
        n_vec++; if (sum_ed !== 48'd1 || err_count !== 16'd1) begin n_err++; $display("FAIL midrst_rerun: got sum %0h err %0h want 1/1", sum_ed, err_count); end
    endtask

    task automatic test_random();
        exp_t e, e34, es;
        int n;
        logic [15:0] ex;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) begin
                sa[i] = 16'($urandom); sb[i] = 16'($urandom); ex = sa[i] + sb[i];
                case ($urandom_range(0, 3))
                    0: sx[i] = {1'b0, ex};
                    1: sx[i] = {1'b0, ex} + 17'($urandom_range(0, 3));
                    2: sx[i] = 17'($urandom);
                    default: sx[i] = {1'b0, ex} ^ (17'd1 << $urandom_range(0, 16));
                endcase
            end
            do_run(n, 1'($urandom_range(0, 1)), -1, 1);
            e = model(n, 16, 48); e34 = model(n, 16, 34); es = model(n, 4, 10);
            n_vec++; if (acc_cnt != n || done_cyc - last_acc != 3) begin n_err++; $display("FAIL rand%0d_handshake: got %0d accepts latency %0d want %0d/3", r, acc_cnt, done_cyc - last_acc, n); end
            n_vec++; if (64'(err_count) !== e.err) begin n_err++; $display("FAIL rand%0d_err_count: got %0h want %0h", r, err_count, e.err); end
            n_vec++; if (64'(max_ed) !== e.mx) begin n_err++; $display("FAIL rand%0d_max_ed: got %0h want %0h", r, max_ed, e.mx); end
            n_vec++; if (64'(sum_ed) !== e.sum) begin n_err++; $display("FAIL rand%0d_sum_ed: got %0h want %0h", r, sum_ed, e.sum); end
            n_vec++; if (64'(sse) !== e.sse || sat !== e.sat) begin n_err++; $display("FAIL rand%0d_sse_sat: got %0h/%b want %0h/%b", r, sse, sat, e.sse, e.sat); end
            n_vec++; if (64'(t_sum) !== e34.sum || 64'(t_sse) !== e34.sse || t_sat !== e34.sat) begin n_err++; $display("FAIL rand%0d_d34: got %0h/%0h/%b want %0h/%0h/%b", r, t_sum, t_sse, t_sat, e34.sum, e34.sse, e34.sat); end
            n_vec++; if (64'(s_err) !== es.err || 64'(s_max) !== es.mx) begin n_err++; $display("FAIL rand%0d_small_cnt: got %0h/%0h want %0h/%0h", r, s_err, s_max, es.err, es.mx); end
            n_vec++; if (64'(s_sum) !== es.sum || 64'(s_sse) !== es.sse || s_sat !== es.sat) begin n_err++; $display("FAIL rand%0d_small_acc: got %0h/%0h/%b want %0h/%0h/%b", r, s_sum, s_sse, s_sat, es.sum, es.sse, es.sat); end
        end
    endtask

    task automatic test_sat_sse();
        set_s(0, 16'd0, 16'd0, 17'h1FFFF);
        set_s(1, 16'd0, 16'd0, 17'h1FFFF);
        do_run(2, 1'b0, -1, 1);
        n_vec++; if (t_sse !== (SSE_ON ? 34'h3_FFFF_FFFF : 34'h0)) begin n_err++; $display("FAIL satsse_sse: got %0h want %0h", t_sse, SSE_ON ? 34'h3_FFFF_FFFF : 34'h0); end
        n_vec++; if (t_sat !== SSE_ON) begin n_err++; $display("FAIL satsse_sat: got %b want %b", t_sat, SSE_ON); end
        n_vec++; if (t_sum !== 34'h3FFFE || t_max !== 17'h1FFFF || t_err !== 16'd2) begin n_err++; $display("FAIL satsse_stats: got %0h/%0h/%0h want 3fffe/1ffff/2", t_sum, t_max, t_err); end
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (t_sat !== SSE_ON || t_busy !== 1'b0 || t_done !== 1'b0) begin n_err++; $display("FAIL satsse_hold: got sat %b busy %b done %b want %b/0/0", t_sat, t_busy, t_done, SSE_ON); end
        set_s(0, 16'd1, 16'd1, 17'd3);
        do_run(1, 1'b0, -1, 1);
        n_vec++; if (t_sat !== 1'b0 || t_sse !== 34'(SSE_ON)) begin n_err++; $display("FAIL satsse_clear: got sat %b sse %0h want 0/%0h", t_sat, t_sse, SSE_ON); end
    endtask

    task automatic test_sat_sum();
        for (int i = 0; i < 40; i++) set_s(i, 16'd0, 16'd0, 17'h0001F);
        do_run(40, 1'b0, -1, 1);
        n_vec++; if (s_sum !== 10'h3FF || s_sat !== 1'b1) begin n_err++; $display("FAIL satsum_small: got sum %0h sat %b want 3ff/1", s_sum, s_sat); end
        n_vec++; if (s_sse !== (SSE_ON ? 10'h3FF : 10'h0) || s_err !== 8'd40 || s_max !== 5'h1F) begin n_err++; $display("FAIL satsum_small_other: got %0h/%0h/%0h", s_sse, s_err, s_max); end
        n_vec++; if (sum_ed !== 48'd1240 || sat !== 1'b0) begin n_err++; $display("FAIL satsum_main: got sum %0h sat %b want 4d8/0", sum_ed, sat); end
        n_vec++; if (s_busy !== 1'b0 || s_rdy !== 1'b0 || s_done !== 1'b0) begin n_err++; $display("FAIL satsum_small_ctrl: got %b%b%b want 000", s_busy, s_rdy, s_done); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_four();
        test_toggle();
        test_zero();
        test_start_in_run();
        test_back_to_back();
        test_midrun_reset();
        test_random();
        test_sat_sse();
        test_sat_sum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
